// File: rtl/i2c_cmd_scheduler.sv
// I2C transaction scheduler: arbitrates two requesters round-robin and
// sequences START / address / two data bytes / STOP commands to a byte
// engine, with NACK handling and a per-command completion timeout.
module i2c_cmd_scheduler #(
    parameter int TIMEOUT = 4095,
    parameter int TW      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [6:0]  req0_addr,
    input  logic [6:0]  req1_addr,
    input  logic        req0_rw,
    input  logic        req1_rw,
    input  logic [15:0] req0_wdata,
    input  logic [15:0] req1_wdata,
    output logic        req0_done,
    output logic        req1_done,
    output logic [15:0] rdata,
    output logic [1:0]  err,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    output logic [7:0]  cmd_data,
    input  logic        cmd_ready,
    input  logic        cmd_done,
    input  logic        cmd_nack,
    input  logic [7:0]  cmd_rdata,
    output logic        bus_abort
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_BYTE0 = 3'd3,
        S_BYTE1 = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [2:0]    C_START     = 3'd0;
    localparam logic [2:0]    C_WRITE     = 3'd1;
    localparam logic [2:0]    C_READ_ACK  = 3'd2;
    localparam logic [2:0]    C_READ_NACK = 3'd3;
    localparam logic [2:0]    C_STOP      = 3'd4;
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_ONE    = TW'(1);

    state_t          state_r;
    state_t          state_n;
    logic [6:0]      addr_r;
    logic            rw_r;
    logic [15:0]     wdata_r;
    logic            last_r;      // 1 = req1 was granted most recently
    logic            wait_r;      // command accepted, awaiting cmd_done
    logic [TW-1:0]   tcnt_r;
    logic            accept_s;
    logic            finish_s;
    logic            tmo_s;
    logic            win_s;
    logic            start_s;
    logic            enter_s;
    logic            cmd_state_s;
    logic [2:0]      cmd_n_s;
    logic [7:0]      data_n_s;

    assign accept_s = cmd_valid && cmd_ready;
    assign finish_s = wait_r && cmd_done;
    assign tmo_s    = wait_r && !cmd_done && (tcnt_r == TMO_LAST);
    assign start_s  = (state_r == S_IDLE) && (state_n == S_START);
    assign enter_s  = cmd_state_s && (state_n != state_r);

    // Round-robin winner: on a tie the requester not granted last wins.
    always_comb begin
        win_s = 1'b0;
        if (req0_valid && req1_valid) begin
            win_s = ~last_r;
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic: advance on completion, bail out to DONE on timeout.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE:  state_n = (req0_valid || req1_valid) ? S_START : S_IDLE;
            S_START: state_n = tmo_s ? S_DONE : (finish_s ? S_ADDR : S_START);
            S_ADDR: begin
                if (tmo_s) begin
                    state_n = S_DONE;
                end else if (finish_s) begin
                    state_n = cmd_nack ? S_STOP : S_BYTE0;
                end else begin
                    state_n = S_ADDR;
                end
            end
            S_BYTE0: begin
                if (tmo_s) begin
                    state_n = S_DONE;
                end else if (finish_s) begin
                    state_n = (!rw_r && cmd_nack) ? S_STOP : S_BYTE1;
                end else begin
                    state_n = S_BYTE0;
                end
            end
            S_BYTE1: state_n = tmo_s ? S_DONE : (finish_s ? S_STOP : S_BYTE1);
            S_STOP:  state_n = (tmo_s || finish_s) ? S_DONE : S_STOP;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Output decode: the command that belongs to the state being entered.
    always_comb begin
        cmd_n_s     = C_START;
        data_n_s    = 8'h00;
        cmd_state_s = 1'b1;
        case (state_n)
            S_START: begin
                cmd_n_s  = C_START;
                data_n_s = 8'h00;
            end
            S_ADDR: begin
                cmd_n_s  = C_WRITE;
                data_n_s = {addr_r, rw_r};
            end
            S_BYTE0: begin
                if (rw_r) begin
                    cmd_n_s  = C_READ_ACK;
                    data_n_s = 8'h00;
                end else begin
                    cmd_n_s  = C_WRITE;
                    data_n_s = wdata_r[15:8];
                end
            end
            S_BYTE1: begin
                if (rw_r) begin
                    cmd_n_s  = C_READ_NACK;
                    data_n_s = 8'h00;
                end else begin
                    cmd_n_s  = C_WRITE;
                    data_n_s = wdata_r[7:0];
                end
            end
            S_STOP: begin
                cmd_n_s  = C_STOP;
                data_n_s = 8'h00;
            end
            default: begin
                cmd_n_s     = C_START;
                data_n_s    = 8'h00;
                cmd_state_s = 1'b0;
            end
        endcase
    end

    // Command handshake: present on state entry, drop on accept, then time the wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd       <= 3'd0;
            cmd_data  <= 8'h00;
            wait_r    <= 1'b0;
            tcnt_r    <= '0;
        end else begin
            if (enter_s) begin
                cmd_valid <= 1'b1;
                cmd       <= cmd_n_s;
                cmd_data  <= data_n_s;
            end else if (accept_s) begin
                cmd_valid <= 1'b0;
            end
            if (accept_s) begin
                wait_r <= 1'b1;
                tcnt_r <= '0;
            end else if (wait_r) begin
                tcnt_r <= tcnt_r + TCNT_ONE;
                if (finish_s || tmo_s) begin
                    wait_r <= 1'b0;
                end
            end
        end
    end

    // Transaction context: request latch, ownership, error and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= 7'd0;
            rw_r    <= 1'b0;
            wdata_r <= 16'h0000;
            grant   <= 2'b00;
            last_r  <= 1'b1;
            err     <= 2'd0;
            rdata   <= 16'h0000;
        end else begin
            if (start_s) begin
                addr_r  <= win_s ? req1_addr  : req0_addr;
                rw_r    <= win_s ? req1_rw    : req0_rw;
                wdata_r <= win_s ? req1_wdata : req0_wdata;
                grant   <= win_s ? 2'b10 : 2'b01;
                last_r  <= win_s;
                err     <= 2'd0;
            end else if (state_r == S_DONE) begin
                grant <= 2'b00;
            end
            if (tmo_s) begin
                err <= 2'd3;
            end else if (finish_s && cmd_nack && (state_r == S_ADDR)) begin
                err <= 2'd1;
            end else if (finish_s && cmd_nack && !rw_r &&
                         ((state_r == S_BYTE0) || (state_r == S_BYTE1))) begin
                err <= 2'd2;
            end
            if (finish_s && rw_r && (state_r == S_BYTE0)) begin
                rdata[15:8] <= cmd_rdata;
            end else if (finish_s && rw_r && (state_r == S_BYTE1)) begin
                rdata[7:0] <= cmd_rdata;
            end
        end
    end

    // Status: done pulse to the owner on DONE entry, abort pulse, busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            bus_abort <= 1'b0;
            busy      <= 1'b0;
        end else begin
            req0_done <= (state_n == S_DONE) && (state_r != S_DONE) && grant[0];
            req1_done <= (state_n == S_DONE) && (state_r != S_DONE) && grant[1];
            bus_abort <= tmo_s;
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: doc/i2c_cmd_scheduler.md
I2C_CMD_SCHEDULER -- requirements
Module: i2c_cmd_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4095: maximum cycles to wait for cmd_done after a command is accepted.
REQ-002 SHALL have parameter TW, default 12: timeout counter width; TIMEOUT < 2**TW.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  transaction request, held high until the matching done pulse.
REQ-006 SHALL have ports req0_addr / req1_addr  input  7  target slave address.
REQ-007 SHALL have ports req0_rw / req1_rw  input  1  0 = write, 1 = read.
REQ-008 SHALL have ports req0_wdata / req1_wdata  input  16  write payload; [15:8] is sent first.
REQ-009 SHALL have ports req0_done / req1_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  16  read result; [15:8] is the first byte received.
REQ-011 SHALL have port err  output  2  0 = ok, 1 = address NACK, 2 = data NACK, 3 = timeout.
REQ-012 SHALL have port grant  output  2  one-hot current owner; 0 when idle.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port cmd_valid  output  1  command to byte engine.
REQ-015 SHALL have port cmd  output  3  command code: 0 = START, 1 = WRITE, 2 = READ_ACK, 3 = READ_NACK, 4 = STOP.
REQ-016 SHALL have port cmd_data  output  8  write byte for the WRITE command.
REQ-017 SHALL have port cmd_ready  input  1  engine accepts the command when cmd_valid && cmd_ready.
REQ-018 SHALL have port cmd_done  input  1  one-cycle pulse when the engine finishes the accepted command.
REQ-019 SHALL have port cmd_nack  input  1  sampled with cmd_done on WRITE commands; 1 = slave NACK.
REQ-020 SHALL have port cmd_rdata  input  8  sampled with cmd_done on READ commands.
REQ-021 SHALL have port bus_abort  output  1  one-cycle pulse on timeout.

Function
REQ-022 SHALL implement states IDLE, START, ADDR, BYTE0, BYTE1, STOP, DONE.
REQ-023 IDLE: if any reqN_valid, SHALL latch addr/rw/wdata of the winner, set grant, go to START.
REQ-024 Arbitration SHALL be round-robin; if both requesters are valid, the one not granted last wins; after reset req0 wins the first tie.
REQ-025 First cmd_valid SHALL appear the cycle after the IDLE grant cycle (latency 1 cycle).
REQ-026 In each command state, cmd_valid SHALL be held with cmd/cmd_data stable until accepted, then deasserted, then cmd_done awaited.
REQ-027 Command per state SHALL be:
- START: START
- ADDR: WRITE {addr, rw}
- BYTE0: WRITE wdata[15:8], or READ_ACK when rw = 1
- BYTE1: WRITE wdata[7:0], or READ_NACK when rw = 1
- STOP: STOP
REQ-028 Each state SHALL advance on cmd_done; a cmd_done with no outstanding command SHALL be ignored.
REQ-029 ADDR with cmd_nack = 1 SHALL set err = 1 and go to STOP, skipping the data bytes.
REQ-030 A write byte with cmd_nack = 1 SHALL set err = 2 and go to STOP.
REQ-031 Read bytes SHALL load rdata[15:8] on the BYTE0 done and rdata[7:0] on the BYTE1 done; rdata SHALL hold until the next read.
REQ-032 The timeout counter SHALL clear on each accept and increment while awaiting cmd_done.
REQ-033 When the counter reaches TIMEOUT, the block SHALL pulse bus_abort, set err = 3, and go directly to DONE; this also applies in STOP.
REQ-034 DONE SHALL pulse the owner's reqN_done for one cycle with err valid, clear grant, and return to IDLE.
REQ-035 A requester dropping valid mid-transaction SHALL NOT abort it; done is still pulsed.
REQ-036 A new transaction SHALL not be granted before the cycle after DONE; err SHALL be cleared at grant.

Reset
REQ-037 On reset, all outputs SHALL be 0, the state SHALL be IDLE, the counter 0, and the round-robin pointer set to "req1 last".
REQ-038 Reset asserted mid-transaction SHALL return to IDLE immediately, with no STOP issued and no done pulse.

Verification
REQ-039 Write: req0 addr = 0x00, rw = 0, wdata = 0xA55A, engine ready, no NACK -> cmd sequence START, WRITE 0x00, WRITE 0xA5, WRITE 0x5A, STOP; req0_done with err = 0.
REQ-040 Read: req1 addr = 0x00, rw = 1, engine returns 0x12 then 0x34 -> cmds START, WRITE 0x01, READ_ACK, READ_NACK, STOP; rdata = 0x1234, err = 0.
REQ-041 Address NACK: addr = 0x2A, cmd_nack = 1 on the address byte -> START, WRITE 0x54, STOP; err = 1, no data commands issued.
REQ-042 Arbitration: req0 and req1 valid in the same cycle from reset -> req0 served, then req1; repeat with both valid -> req0 again after req1 (alternation).
REQ-043 Timeout: cmd_done withheld after an accepted WRITE -> bus_abort exactly TIMEOUT cycles after accept, err = 3, done pulsed.
REQ-044 Reset during BYTE0 -> next cycle busy = 0, grant = 0, cmd_valid = 0; a following request completes normally.
